bipolar_estimate_collector: RTL and testbench

- Sits directly downstream of the bipolar sum-tree array. Each cycle it accepts LANES thresholded sign bits, one bit per parallel sum tree.
- Assembles the bits into a full HV_DIM-bit bipolar estimate hypervector.
- Counts bit flips against the previous iteration's estimate and the iteration number.
- Hands the vector to the next stage with convergence and timeout flags for resonator-loop control.

---
 rtl/bipolar_estimate_collector.sv | 169 ++++++++++++++++
 tb/tb_bipolar_estimate_collector.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bipolar_estimate_collector.sv
// Collects LANES sign bits per beat into an HV_DIM-bit bipolar estimate, counting flips vs. the previous estimate.
// Optional HV_EARLY_STOP_EN: parks in DONE after a converged or timed-out estimate transfers.
module bipolar_estimate_collector #(
  parameter int HV_DIM      = 256,
  parameter int LANES       = 8,
  parameter int FLIP_THRESH = 0,
  parameter int MAX_ITER    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES-1:0]            in_bits,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [HV_DIM-1:0]           out_vector,
  output logic [$clog2(HV_DIM+1)-1:0] out_flips,
  output logic                        out_converged,
  output logic                        out_timeout,
  output logic [$clog2(MAX_ITER)-1:0] out_iter
);

  localparam int BEATS = HV_DIM / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int FW    = $clog2(HV_DIM + 1);
  localparam int IW    = $clog2(MAX_ITER);

  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
  localparam logic [FW-1:0] THRESH    = FW'(FLIP_THRESH);
  localparam logic [IW-1:0] ITER_LAST = IW'(MAX_ITER - 1);

`ifdef HV_EARLY_STOP_EN
  typedef enum logic [1:0] {COLLECT, HOLD, DONE} state_t;
`else
  typedef enum logic [1:0] {COLLECT, HOLD} state_t;
`endif

  state_t state_q, state_d;

  logic [BW-1:0]     beat_q, beat_d;
  logic [FW-1:0]     acc_q, acc_d;
  logic [FW-1:0]     flips_q, flips_d;
  logic [IW-1:0]     iter_q, iter_d;
  logic [HV_DIM-1:0] cur_q, cur_d;
  logic [HV_DIM-1:0] prev_q, prev_d;

  logic              beat_fire;
  logic              out_fire;
  logic              last_beat;
  logic [LANES-1:0]  prev_slice;
  logic [FW-1:0]     beat_flips;
  int                shamt;

  function automatic logic [FW-1:0] popcount(input logic [LANES-1:0] v);
    logic [FW-1:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) begin
      n = n + FW'(v[i]);
    end
    return n;
  endfunction

  assign shamt      = int'(beat_q) * LANES;
  assign prev_slice = LANES'(prev_q >> shamt);
  assign beat_flips = popcount(in_bits ^ prev_slice);
  assign last_beat  = (beat_q == BEAT_LAST);
  assign beat_fire  = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready && !clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // clear wins over both handshakes; a transfer may park in DONE when early stop is built in
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = COLLECT;
    end else begin
      case (state_q)
        COLLECT: if (beat_fire && last_beat) state_d = HOLD;
        HOLD: begin
          if (out_fire) begin
`ifdef HV_EARLY_STOP_EN
            state_d = (out_converged || out_timeout) ? DONE : COLLECT;
`else
            state_d = COLLECT;
`endif
          end
        end
`ifdef HV_EARLY_STOP_EN
        DONE:    state_d = DONE;
`endif
        default: state_d = COLLECT;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == COLLECT) && !clear;
    out_valid = (state_q == HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q  <= '0;
      acc_q   <= '0;
      flips_q <= '0;
      iter_q  <= '0;
      cur_q   <= '0;
      prev_q  <= '0;
    end else begin
      beat_q  <= beat_d;
      acc_q   <= acc_d;
      flips_q <= flips_d;
      iter_q  <= iter_d;
      cur_q   <= cur_d;
      prev_q  <= prev_d;
    end
  end

  // Flips accumulate per beat against the matching slice of the previous estimate
  always_comb begin
    beat_d  = beat_q;
    acc_d   = acc_q;
    flips_d = flips_q;
    iter_d  = iter_q;
    cur_d   = cur_q;
    prev_d  = prev_q;
    if (clear) begin
      beat_d  = '0;
      acc_d   = '0;
      flips_d = '0;
      iter_d  = '0;
      prev_d  = '0;
    end else begin
      if (beat_fire) begin
        cur_d = (cur_q & ~({{(HV_DIM-LANES){1'b0}}, {LANES{1'b1}}} << shamt))
              | (HV_DIM'(in_bits) << shamt);
        if (last_beat) begin
          beat_d  = '0;
          acc_d   = '0;
          flips_d = acc_q + beat_flips;
        end else begin
          beat_d = beat_q + 1'b1;
          acc_d  = acc_q + beat_flips;
        end
      end
      if (out_fire) begin
        prev_d = cur_q;
        beat_d = '0;
        acc_d  = '0;
        iter_d = (iter_q == ITER_LAST) ? iter_q : iter_q + 1'b1;
      end
    end
  end

  assign out_vector    = cur_q;
  assign out_flips     = flips_q;
  assign out_iter      = iter_q;
  assign out_converged = (iter_q != '0) && (flips_q <= THRESH);
  assign out_timeout   = (iter_q == ITER_LAST);

endmodule

// File: tb/tb_bipolar_estimate_collector.sv
// Randomised bench for bipolar_estimate_collector; expected estimates come from a vector-level model
// (previous estimate + iteration count, flips via $countones).
module tb_bipolar_estimate_collector;

   localparam int HV    = 256;
   localparam int L     = 8;
   localparam int BEATS = HV / L;
   localparam int MAXI  = 16;
   localparam int THR   = 0;

   logic          clk = 1'b0;
   logic          rst;
   logic          clear;
   logic          in_valid;
   logic          in_ready;
   logic [L-1:0]  in_bits;
   logic          out_valid;
   logic          out_ready;
   logic [HV-1:0] out_vector;
   logic [8:0]    out_flips;
   logic          out_converged;
   logic          out_timeout;
   logic [3:0]    out_iter;

   int checks = 0;
   int errors = 0;

   logic [HV-1:0] mPrev;
   int            mIter;

   bipolar_estimate_collector #(
      .HV_DIM(HV), .LANES(L), .FLIP_THRESH(THR), .MAX_ITER(MAXI)
   ) dut (
      .clk(clk), .rst(rst), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
      .out_valid(out_valid), .out_ready(out_ready), .out_vector(out_vector),
      .out_flips(out_flips), .out_converged(out_converged),
      .out_timeout(out_timeout), .out_iter(out_iter)
   );

   // free-running clock, period 10
   always #5 clk = ~clk;

   // safety net so a stuck design still ends the run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // one comparison: counts it and reports a mismatch
   task automatic checkOutput(input string tag, input logic [HV-1:0] obs, input logic [HV-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [HV-1:0] randVec();
      logic [HV-1:0] v;
      for (int i = 0; i < HV / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // pulse clear for one cycle while offering a junk beat that must not be taken
   task automatic doClear();
      @(negedge clk);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_bits  = L'($urandom);
      out_ready = 1'b1;
      #1 checkOutput("ready_during_clear", in_ready, 1'b0);
      @(negedge clk);
      clear     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      checkOutput("valid_after_clear", out_valid, 1'b0);
      checkOutput("iter_after_clear", out_iter, 0);
      mPrev = '0;
      mIter = 0;
   endtask

   // async reset asserted between clock edges
   task automatic doReset();
      @(negedge clk);
      #2 rst = 1'b1;
      #1 checkOutput("async_rst_vector", out_vector, '0);
      checkOutput("async_rst_iter", out_iter, 0);
      @(negedge clk);
      rst = 1'b0;
      mPrev = '0;
      mIter = 0;
   endtask

   // sends nBeats beats of v; for a full vector also checks the estimate, backpressures, transfers
   task automatic applyStimulus(input logic [HV-1:0] v, input int nBeats, input int bpCycles, input bit gaps);
      int  k;
      int  guard;
      bit  taken;
      int  expFlips;
      bit  expConv;
      bit  expTmo;
      k = 0;
      guard = 0;
      while (k < nBeats && guard < 1000) begin
         @(negedge clk);
         guard++;
         in_valid = gaps ? ($urandom_range(3) != 0) : 1'b1;
         in_bits  = in_valid ? v[k*L +: L] : L'($urandom);
         #1 taken = in_valid && in_ready;
         @(posedge clk);
         if (taken) k++;
      end
      if (k < nBeats) checkOutput("beat_budget", k, nBeats);
      @(negedge clk);
      in_valid = 1'b0;
      if (nBeats < BEATS) return;

      expFlips = $countones(v ^ mPrev);
      expConv  = (mIter != 0) && (expFlips <= THR);
      expTmo   = (mIter == MAXI - 1);
      checkOutput("latency_valid", out_valid, 1'b1);
      checkOutput("vector", out_vector, v);
      checkOutput("flips", out_flips, expFlips);
      checkOutput("iter", out_iter, mIter);
      checkOutput("converged", out_converged, expConv);
      checkOutput("timeout", out_timeout, expTmo);
      checkOutput("hold_ready", in_ready, 1'b0);

      for (int i = 0; i < bpCycles; i++) begin
         in_valid = 1'b1;
         in_bits  = L'($urandom);
         @(negedge clk);
         checkOutput("bp_valid", out_valid, 1'b1);
         checkOutput("bp_ready", in_ready, 1'b0);
         checkOutput("bp_vector", out_vector, v);
         checkOutput("bp_flips", out_flips, expFlips);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      checkOutput("valid_drop", out_valid, 1'b0);
      mPrev = v;
      if (mIter < MAXI - 1) mIter++;
`ifdef HV_EARLY_STOP_EN
      if (expConv || expTmo) begin
         for (int i = 0; i < 3; i++) begin
            checkOutput("done_ready", in_ready, 1'b0);
            checkOutput("done_valid", out_valid, 1'b0);
            @(negedge clk);
         end
         doClear();
      end else begin
         checkOutput("collect_ready", in_ready, 1'b1);
      end
`else
      checkOutput("collect_ready", in_ready, 1'b1);
`endif
   endtask

   initial begin
      logic [HV-1:0] ones;
      logic [HV-1:0] v;
      ones      = '1;
      rst       = 1'b1;
      clear     = 1'b0;
      in_valid  = 1'b0;
      in_bits   = '0;
      out_ready = 1'b0;
      mPrev     = '0;
      mIter     = 0;
      repeat (3) @(negedge clk);
      checkOutput("rst_valid", out_valid, 1'b0);
      checkOutput("rst_vector", out_vector, '0);
      checkOutput("rst_flips", out_flips, 0);
      checkOutput("rst_iter", out_iter, 0);
      checkOutput("rst_flags", {out_converged, out_timeout}, 2'b00);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_ready", in_ready, 1'b1);

      doClear();
      applyStimulus(ones, BEATS, 0, 1'b0);
      applyStimulus(ones, BEATS, 0, 1'b0);

      v = ones;
      v[7:0] = 8'hFE;
      applyStimulus(v, BEATS, 5, 1'b0);

      doClear();
      for (int i = 0; i < MAXI + 1; i++) begin
         applyStimulus((i % 2 == 0) ? ones : '0, BEATS, 0, 1'b0);
      end

      doClear();
      for (int i = 0; i < 6; i++) begin
         applyStimulus(randVec(), BEATS, $urandom_range(3), 1'b1);
      end

      applyStimulus(randVec(), 10, 0, 1'b1);
      doClear();
      applyStimulus(randVec(), BEATS, 1, 1'b1);

      applyStimulus(randVec(), 17, 0, 1'b1);
      doReset();
      applyStimulus(randVec(), BEATS, 2, 1'b1);
      applyStimulus(randVec(), BEATS, 0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
